// File: rtl/conv_layer_sched.sv
// conv_layer_sched: per-layer descriptor table and sequencer that drives the 3x3 PE-array controller.
// Define LAYER_SCHED_PERF_EN to add the run_cycles busy-cycle counter output.
//
// state | meaning
// IDLE  | table writable, waiting for run
// LOAD  | descriptor -> config outputs, legality check
// START | start_conv pulse
// WAIT  | waiting for conv_done
// GAP   | drain down-counter, then advance or finish
// DONE  | all_done pulse
// ERR   | illegal descriptor seen, err set
module conv_layer_sched #(
  parameter int LAYER_NUM   = 8,
  parameter int LAYER_WIDTH = 3,
  parameter int CHN_WIDTH   = 4,
  parameter int FMS_WIDTH   = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int DESC_W      = 2*CHN_WIDTH + FMS_WIDTH + 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cfg_we,
  input  logic [LAYER_WIDTH-1:0] cfg_addr,
  input  logic [DESC_W-1:0]      cfg_wdata,
  input  logic [LAYER_WIDTH:0]   layer_cnt,
  input  logic                   run,
  input  logic                   abort,
  input  logic                   conv_done,
  output logic [CHN_WIDTH-1:0]   chi,
  output logic [CHN_WIDTH-1:0]   cho,
  output logic                   stride,
  output logic [FMS_WIDTH-1:0]   ifm_size,
  output logic                   group,
  output logic                   start_conv,
  output logic                   busy,
  output logic [LAYER_WIDTH-1:0] layer_idx,
  output logic                   layer_done,
  output logic                   all_done,
  output logic                   err
`ifdef LAYER_SCHED_PERF_EN
  ,
  output logic [31:0]            run_cycles
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES);
  localparam logic [LAYER_WIDTH:0] NUM_L = (LAYER_WIDTH+1)'(LAYER_NUM);
  localparam int CHO_LSB = CHN_WIDTH;
  localparam int IFM_LSB = 2*CHN_WIDTH;
  localparam int STR_BIT = IFM_LSB + FMS_WIDTH;
  localparam int GRP_BIT = STR_BIT + 1;

  logic [DESC_W-1:0]      mem_q [LAYER_NUM];
  logic [2:0]             state_q, state_d;
  logic [LAYER_WIDTH-1:0] layer_idx_q, layer_idx_d;
  logic [LAYER_WIDTH:0]   layer_cnt_q, layer_cnt_d;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
  logic [DESC_W-1:0]      cfg_q, cfg_d;
  logic                   err_q, err_d;
  logic                   layer_done_q, layer_done_d;
  logic                   start_conv_q, start_conv_d;
  logic                   all_done_q, all_done_d;
  logic                   busy_q, busy_d;
  logic [DESC_W-1:0]      desc_rd;
  logic                   desc_bad;
  logic                   last_layer;

  assign desc_rd  = mem_q[layer_idx_q];
  assign desc_bad = (desc_rd[IFM_LSB +: FMS_WIDTH] < FMS_WIDTH'(3)) ||
                    (desc_rd[0 +: CHN_WIDTH] == '0) ||
                    (desc_rd[CHO_LSB +: CHN_WIDTH] == '0);
  assign last_layer = ({1'b0, layer_idx_q} + (LAYER_WIDTH+1)'(1)) == layer_cnt_q;

  // Table is only writable while idle so a running layer never sees its descriptor change.
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == S_IDLE && {1'b0, cfg_addr} < NUM_L)
      mem_q[cfg_addr] <= cfg_wdata;
  end

  always_comb begin
    state_d      = state_q;
    layer_idx_d  = layer_idx_q;
    layer_cnt_d  = layer_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cfg_d        = cfg_q;
    err_d        = err_q;
    layer_done_d = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            if (layer_cnt == '0) begin
              state_d = S_DONE;
            end else begin
              layer_cnt_d = (layer_cnt > NUM_L) ? NUM_L : layer_cnt;
              layer_idx_d = '0;
              err_d       = 1'b0;
              state_d     = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          cfg_d = desc_rd;
          if (desc_bad) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            state_d = S_START;
          end
        end
        S_START: state_d = S_WAIT;
        S_WAIT: begin
          if (conv_done) begin
            layer_done_d = 1'b1;
            gap_cnt_d    = GAP_INIT;
            state_d      = S_GAP;
          end
        end
        // Terminal count doubles as the advance-decision cycle, so a zero gap still takes one cycle.
        S_GAP: begin
          if (gap_cnt_q == '0) begin
            if (last_layer) begin
              state_d = S_DONE;
            end else begin
              layer_idx_d = layer_idx_q + LAYER_WIDTH'(1);
              state_d     = S_LOAD;
            end
          end else begin
            gap_cnt_d = gap_cnt_q - GW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    start_conv_d = (state_d == S_START);
    all_done_d   = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      layer_idx_q  <= '0;
      layer_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      cfg_q        <= '0;
      err_q        <= 1'b0;
      layer_done_q <= 1'b0;
      start_conv_q <= 1'b0;
      all_done_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_idx_q  <= layer_idx_d;
      layer_cnt_q  <= layer_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      cfg_q        <= cfg_d;
      err_q        <= err_d;
      layer_done_q <= layer_done_d;
      start_conv_q <= start_conv_d;
      all_done_q   <= all_done_d;
      busy_q       <= busy_d;
    end
  end

`ifdef LAYER_SCHED_PERF_EN
  logic [31:0] run_cycles_q, run_cycles_d;

  always_comb begin
    run_cycles_d = run_cycles_q;
    if (state_q == S_IDLE && run && !abort)
      run_cycles_d = '0;
    else if (busy_q && run_cycles_q != 32'hFFFF_FFFF)
      run_cycles_d = run_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) run_cycles_q <= '0;
    else       run_cycles_q <= run_cycles_d;
  end

  assign run_cycles = run_cycles_q;
`endif

  assign chi        = cfg_q[0 +: CHN_WIDTH];
  assign cho        = cfg_q[CHO_LSB +: CHN_WIDTH];
  assign ifm_size   = cfg_q[IFM_LSB +: FMS_WIDTH];
  assign stride     = cfg_q[STR_BIT];
  assign group      = cfg_q[GRP_BIT];
  assign start_conv = start_conv_q;
  assign busy       = busy_q;
  assign layer_idx  = layer_idx_q;
  assign layer_done = layer_done_q;
  assign all_done   = all_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Scoreboard bench for conv_layer_sched: the run model predicts event cycles and payloads, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_conv_layer_sched;
  localparam int G = 4;
  localparam int K_ST = 0, K_LD = 1, K_AD = 2, K_ER = 3;

  logic        clk = 1'b0, rstn = 1'b0, cfg_we = 1'b0, run = 1'b0, abort = 1'b0, conv_done = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [17:0] cfg_wdata = 18'd0;
  logic [3:0]  layer_cnt = 4'd0;
  logic [3:0]  chi, cho;
  logic        stride, group, start_conv, busy, layer_done, all_done, err;
  logic [7:0]  ifm_size;
  logic [2:0]  layer_idx;
`ifdef LAYER_SCHED_PERF_EN
  logic [31:0] run_cycles;
`endif

  conv_layer_sched dut (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .layer_cnt(layer_cnt), .run(run), .abort(abort), .conv_done(conv_done),
    .chi(chi), .cho(cho), .stride(stride), .ifm_size(ifm_size), .group(group),
    .start_conv(start_conv), .busy(busy), .layer_idx(layer_idx), .layer_done(layer_done),
    .all_done(all_done), .err(err)
`ifdef LAYER_SCHED_PERF_EN
    , .run_cycles(run_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          at;
    logic [17:0] desc;
    int          idx;
  } ev_t;

  ev_t         exp_q[$];
  logic [17:0] tbl_m [8];
  int          dly [8];
  int          checks = 0;
  int          errors = 0;
  bit          m_err = 1'b0;
  logic        err_prev = 1'b0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic void push(input int kind, input int at, input logic [17:0] d, input int idx);
    ev_t e;
    e.kind = kind; e.at = at; e.desc = d; e.idx = idx;
    exp_q.push_back(e);
  endfunction

  function automatic bit legal(input logic [17:0] d);
    return (d[15:8] >= 8'd3) && (d[3:0] != 4'd0) && (d[7:4] != 4'd0);
  endfunction

  function automatic logic [17:0] mk(input logic [3:0] ci, input logic [3:0] co, input logic s,
                                     input logic [7:0] ifm);
    return {1'b0, s, ifm, co, ci};
  endfunction

  task automatic mon(input int kind, input logic [17:0] d, input int idx);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != cyc || (kind == K_ST && (e.desc !== d || e.idx != idx))) begin
        errors++;
        $display("FAIL event: got kind %0d cyc %0d desc %0h idx %0d, expected kind %0d cyc %0d desc %0h idx %0d",
                 kind, cyc, d, idx, e.kind, e.at, e.desc, e.idx);
      end
    end
  endtask

  always @(negedge clk) begin
    if (layer_done) mon(K_LD, 18'd0, 0);
    if (all_done)   mon(K_AD, 18'd0, 0);
    if (start_conv) mon(K_ST, {group, stride, ifm_size, cho, chi}, int'(layer_idx));
    if (err && !err_prev) mon(K_ER, 18'd0, 0);
    err_prev = err;
  end

  task automatic wr(input int a, input logic [17:0] d);
    cfg_we = 1'b1; cfg_addr = a[2:0]; cfg_wdata = d; tbl_m[a] = d;
    step(1);
    cfg_we = 1'b0;
  endtask

  // cut: 0 none, 1 abort with conv_done of layer cut_k, 2 reset in the gap after layer cut_k
  task automatic do_run(input int n_req, input int cut, input int cut_k, input bit poke);
    int n, t, s, end_t, nconv;
    int w [8];
    bit stop;
    n = (n_req > 8) ? 8 : n_req;
    t = cyc; nconv = 0; stop = 1'b0; end_t = t + 2; s = t + 2;
    if (n == 0) push(K_AD, t + 1, 18'd0, 0);
    else m_err = 1'b0;
    for (int k = 0; k < n && !stop; k++) begin
      if (!legal(tbl_m[k])) begin
        push(K_ER, s, 18'd0, 0);
        end_t = s + 1; stop = 1'b1; m_err = 1'b1;
      end else begin
        push(K_ST, s, tbl_m[k], k);
        w[k] = s + dly[k]; nconv++;
        if (cut == 1 && k == cut_k) begin
          end_t = w[k] + 1; stop = 1'b1;
        end else begin
          push(K_LD, w[k] + 1, 18'd0, 0);
          if (cut == 2 && k == cut_k) begin
            end_t = w[k] + 3; stop = 1'b1;
          end else if (k == n - 1) begin
            push(K_AD, w[k] + G + 2, 18'd0, 0);
            end_t = w[k] + G + 3;
          end else begin
            s = w[k] + G + 3;
          end
        end
      end
    end
    run = 1'b1; layer_cnt = n_req[3:0];
    step(1);
    run = 1'b0;
    if (n == 0) begin
      chk("zero_busy_t1", busy, 1);
      step(1);
      chk("zero_busy_t2", busy, 0);
    end else begin
      chk("err_cleared_on_run", err, 0);
    end
    for (int k = 0; k < nconv; k++) begin
      if (poke && k == 0) begin
        wait_until(t + 3);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = ~tbl_m[0]; run = 1'b1; layer_cnt = 4'd5;
        step(1);
        cfg_we = 1'b0; run = 1'b0; layer_cnt = n_req[3:0];
      end
      wait_until(w[k]);
      conv_done = 1'b1;
      if (cut == 1 && k == cut_k) abort = 1'b1;
      step(1);
      conv_done = 1'b0; abort = 1'b0;
      if (cut == 1 && k == cut_k) begin
        chk("abort_idle", busy, 0);
        chk("abort_idx_hold", layer_idx, cut_k);
        chk("abort_chi_hold", chi, tbl_m[cut_k][3:0]);
      end
      if (cut == 2 && k == cut_k) begin
        wait_until(w[k] + 2);
        rstn = 1'b0;
        step(1);
        rstn = 1'b1; m_err = 1'b0;
        chk("reset_mid_outputs", {chi, cho, stride, ifm_size, group, start_conv, busy, layer_idx,
                                  layer_done, all_done, err}, 0);
      end
    end
    wait_until(end_t + 2);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_after_run", busy, 0);
    chk("err_flag", err, m_err);
`ifdef LAYER_SCHED_PERF_EN
    if (n == 1 && cut == 0 && legal(tbl_m[0])) chk("run_cycles", run_cycles, end_t - 1 - t);
`endif
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [17:0] d;
    int nr;
    step(2);
    chk("reset_outputs", {chi, cho, stride, ifm_size, group, start_conv, busy, layer_idx,
                          layer_done, all_done, err}, 0);
    rstn = 1'b1;
    step(1);

    wr(0, mk(4'd1, 4'd2, 1'b0, 8'd18));
    wr(1, mk(4'd2, 4'd2, 1'b1, 8'd34));
    wr(2, mk(4'd1, 4'd1, 1'b0, 8'd10));
    for (int a = 3; a < 8; a++) wr(a, mk(4'(a), 4'd3, a[0], 8'(a * 5)));
    for (int a = 0; a < 8; a++) dly[a] = 20;

    do_run(3, 0, 0, 1'b0);
    do_run(0, 0, 0, 1'b0);

    wr(1, mk(4'd2, 4'd2, 1'b1, 8'd2));
    do_run(2, 0, 0, 1'b0);
    wr(1, mk(4'd2, 4'd2, 1'b1, 8'd34));
    do_run(2, 0, 0, 1'b0);

    do_run(2, 1, 1, 1'b0);
    do_run(1, 0, 0, 1'b0);

    dly[0] = 10;
    do_run(2, 0, 0, 1'b1);
    do_run(2, 0, 0, 1'b0);
    conv_done = 1'b1;
    step(1);
    conv_done = 1'b0;
    step(3);
    chk("conv_done_in_idle", busy, 0);

    do_run(2, 2, 0, 1'b0);
    do_run(1, 0, 0, 1'b0);
    do_run(12, 0, 0, 1'b0);

    repeat (15) begin
      for (int a = 0; a < 8; a++) begin
        d = 18'($urandom);
        if ($urandom_range(0, 7) != 0) begin
          if (d[3:0] == 4'd0) d[3:0] = 4'd1;
          if (d[7:4] == 4'd0) d[7:4] = 4'd1;
          if (d[15:8] < 8'd3) d[15:8] = 8'd3;
        end
        wr(a, d);
        dly[a] = $urandom_range(1, 25);
      end
      nr = $urandom_range(0, 15);
      do_run(nr, 0, 0, 1'b0);
    end

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
